tile_blitter_param: RTL and testbench
=====================================

// Module: tile_blitter_param
// PURPOSE
//  Parametrised successor of the fixed 8x8 tile drawer. Reads a TILE_W x TILE_H tile of
//  packed 24-bit RGB (R,G,B bytes, row-major) from byte-wide ROM and plots it at (x_pos,y_pos).
//  Adds: configurable ROM latency, vga_ready backpressure, optional colour-key transparency,
//  horizontal flip, start/busy/done handshake. Shares the VGA plot bus with other drawers.
// PARAMETERS
//  TILE_W       8         tile width in pixels (1..16)
//  TILE_H       8         tile height in pixels (1..16)
//  COORD_W      8         screen coordinate width
//  ADDR_W       12        ROM byte-address width
//  ROM_LATENCY  2         cycles from rom_addr change to valid rom_data (1..4)
//  KEY_EN       1         1 = pixels equal to KEY_RGB are skipped (not plotted)
//  KEY_RGB      24'hFF00FF transparency colour key
// PORTS
//  clk          in   1        system clock, all logic on posedge
//  reset        in   1        synchronous, active-high
//  start        in   1        1-cycle request; sampled only in IDLE
//  tile_addr    in   ADDR_W   ROM byte address of pixel 0 R byte; latched on start
//  x_pos        in   COORD_W  tile origin x; latched on start
//  y_pos        in   COORD_W  tile origin y; latched on start
//  flip_x       in   1        1 = mirror columns on screen; latched on start
//  rom_addr     out  ADDR_W   registered ROM byte address
//  rom_data     in   8        ROM read data
//  vga_ready    in   1        plot sink accepts vga_plot this cycle
//  vga_x        out  COORD_W  plot x (tri-state Z when busy=0)
//  vga_y        out  COORD_W  plot y (tri-state Z when busy=0)
//  vga_rgb      out  24       plot colour {R,G,B} (tri-state Z when busy=0)
//  vga_plot     out  1        plot strobe (tri-state Z when busy=0)
//  busy         out  1        1 from cycle after accepted start until done
//  done         out  1        1-cycle pulse after final pixel handled
// BEHAVIOUR
//  Reset: state=IDLE; rom_addr=0, busy=0, done=0, internal vga regs=0 (bus outputs Z).
//  Reset mid-tile aborts immediately; no done pulse; no further plots.
//  States: IDLE -> FETCH (start) ; FETCH -> CHECK after 3 bytes ; CHECK -> PLOT (opaque)
//   or NEXT (keyed) ; PLOT -> NEXT when vga_plot && vga_ready ; NEXT -> FETCH (pixels left)
//   or DONE ; DONE -> IDLE (done=1 this cycle, busy drops next cycle).
//  FETCH: byte b (0=R,1=G,2=B) of pixel p at address tile_addr + 3*p + b, modulo 2^ADDR_W.
//   rom_addr registered; rom_data captured exactly ROM_LATENCY cycles after rom_addr update;
//   each byte costs ROM_LATENCY+1 cycles, bytes strictly sequential (no overlap).
//  Pixel p: row = p / TILE_W, col = p % TILE_W; ROM order never changes with flip.
//   vga_x = x_pos + (flip_x ? TILE_W-1-col : col), vga_y = y_pos + row, both mod 2^COORD_W.
//  PLOT: vga_x/y/rgb stable and vga_plot=1 until vga_ready=1; exactly one accepted plot per
//   opaque pixel; vga_plot=0 in every other state.
//  KEY_EN=1 and rgb==KEY_RGB: pixel skipped, no plot; KEY_EN=0: every pixel plotted.
//  Latency per opaque pixel with vga_ready=1: 3*(ROM_LATENCY+1)+2 cycles.
//  start while busy: ignored, not queued. start and reset same cycle: reset wins.
//  Counter widths sized for TILE_W*TILE_H; last pixel index TILE_W*TILE_H-1 then DONE.
// TESTING
//  T1 defaults, tile_addr=0, ROM byte n = n[7:0], x=10,y=20 -> 64 plots, first (10,20)
//     rgb 00_01_02, last (17,27) rgb BD_BE_BF, done once, busy low after.
//  T2 flip_x=1 same tile -> pixel 0 at (17,20), pixel 7 at (10,20); colours as T1.
//  T3 vga_ready low 5 cycles on pixel 3 -> vga_plot/x/y/rgb held constant, no duplicate or
//     lost plot; total plots 64.
//  T4 KEY_EN=1, pixels 5 and 63 = FF00FF -> 62 plots, those coordinates never plotted,
//     done still pulses.
//  T5 x_pos=250, tile_addr=12'hFFE -> x wraps 250..255,0,1; rom_addr wraps FFE,FFF,000.
//  T6 reset asserted mid-pixel 10, start repeated while busy -> immediate IDLE, outputs Z,
//     no done; extra starts ignored; fresh start after reset draws full tile.

Source files
------------

// File: rtl/tile_blitter_param.sv
// Tile blitter: fetches a TILE_W x TILE_H tile of packed RGB bytes from a fixed-latency ROM
// and plots it on a shared VGA plot bus, with colour-key skip, horizontal flip and backpressure.
module tile_blitter_param #(
    parameter int          TILE_W      = 8,
    parameter int          TILE_H      = 8,
    parameter int          COORD_W     = 8,
    parameter int          ADDR_W      = 12,
    parameter int          ROM_LATENCY = 2,
    parameter bit          KEY_EN      = 1'b1,
    parameter logic [23:0] KEY_RGB     = 24'hFF00FF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  tile_addr,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic               flip_x,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [7:0]         rom_data,
    input  logic               vga_ready,
    output logic [COORD_W-1:0] vga_x,
    output logic [COORD_W-1:0] vga_y,
    output logic [23:0]        vga_rgb,
    output logic               vga_plot,
    output logic               busy,
    output logic               done
);
    localparam int NPIX = TILE_W * TILE_H;
    localparam int PW   = (NPIX > 1)   ? $clog2(NPIX)   : 1;
    localparam int CW   = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int RW   = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(TILE_W - 1);
    localparam logic [2:0]    LAT      = 3'(ROM_LATENCY);
    localparam logic [2:0]    LAT_M1   = 3'(ROM_LATENCY - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CHECK, S_PLOT, S_NEXT, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PW-1:0]      r_pix;
    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic [1:0]         r_byte;
    logic [2:0]         r_wait;
    logic [COORD_W-1:0] r_x0;
    logic [COORD_W-1:0] r_y0;
    logic               r_flip;
    logic [COORD_W-1:0] r_vga_x;
    logic [COORD_W-1:0] r_vga_y;
    logic [23:0]        r_vga_rgb;
    logic [COORD_W-1:0] w_col_off;
    logic               w_keyed;
    logic               w_busy;
    logic               w_done;
    logic               w_plot;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    assign w_keyed = KEY_EN && (r_vga_rgb == KEY_RGB);

    // The blue byte leaves FETCH on its capture edge; CHECK takes the slot of its idle cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: if (r_byte == 2'd2 && r_wait == LAT_M1) w_next = S_CHECK;
            S_CHECK: w_next = w_keyed ? S_NEXT : S_PLOT;
            S_PLOT:  if (vga_ready) w_next = S_NEXT;
            S_NEXT:  w_next = (r_pix == LAST_PIX) ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_done = (r_state == S_DONE);
        w_plot = (r_state == S_PLOT);
    end

    always_comb begin
        w_col_off = r_flip ? COORD_W'(TILE_W - 1 - int'(r_col)) : COORD_W'(r_col);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr  <= '0;
            r_pix     <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_byte    <= '0;
            r_wait    <= '0;
            r_x0      <= '0;
            r_y0      <= '0;
            r_flip    <= 1'b0;
            r_vga_x   <= '0;
            r_vga_y   <= '0;
            r_vga_rgb <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        rom_addr <= tile_addr;
                        r_x0     <= x_pos;
                        r_y0     <= y_pos;
                        r_flip   <= flip_x;
                        r_pix    <= '0;
                        r_col    <= '0;
                        r_row    <= '0;
                        r_byte   <= '0;
                        r_wait   <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_wait == LAT_M1) begin
                        unique case (r_byte)
                            2'd0:    r_vga_rgb[23:16] <= rom_data;
                            2'd1:    r_vga_rgb[15:8]  <= rom_data;
                            default: r_vga_rgb[7:0]   <= rom_data;
                        endcase
                    end
                    if (r_wait == LAT) begin
                        r_wait   <= '0;
                        r_byte   <= r_byte + 2'd1;
                        rom_addr <= rom_addr + ADDR_W'(1);
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                S_CHECK: begin
                    r_vga_x <= r_x0 + w_col_off;
                    r_vga_y <= r_y0 + COORD_W'(r_row);
                end
                S_NEXT: begin
                    rom_addr <= rom_addr + ADDR_W'(1);
                    r_wait   <= '0;
                    r_byte   <= '0;
                    r_pix    <= r_pix + PW'(1);
                    if (r_col == LAST_COL) begin
                        r_col <= '0;
                        r_row <= r_row + RW'(1);
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = w_busy;
    assign done     = w_done;
    assign vga_x    = w_busy ? r_vga_x   : 'z;
    assign vga_y    = w_busy ? r_vga_y   : 'z;
    assign vga_rgb  = w_busy ? r_vga_rgb : 'z;
    assign vga_plot = w_busy ? w_plot    : 1'bz;

endmodule

// File: tb/tb_tile_blitter_param.sv
// Bench for tile_blitter_param: table of fixed tiles, hand-written stall/key/reset sequences,
// and randomised tiles checked against a plot-list model built from the ROM contents.
module tb_tile_blitter_param;
    typedef logic [39:0] plot_t;  // {x, y, rgb}

    typedef struct {
        logic [11:0] a;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        f;
        int          n;
        plot_t       first;
        plot_t       last;
        logic        chk_wrap;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] tile_addr = '0;
    logic [7:0]  x_pos = '0;
    logic [7:0]  y_pos = '0;
    logic        flip_x = 1'b0;
    logic        vga_ready = 1'b1;
    logic        rdy_rand = 1'b0;
    wire  [11:0] rom_addr;
    wire  [7:0]  rom_data;
    wire  [7:0]  vga_x;
    wire  [7:0]  vga_y;
    wire  [23:0] vga_rgb;
    wire         vga_plot;
    wire         busy;
    wire         done;

    int checks = 0;
    int errors = 0;

    tile_blitter_param #(
        .TILE_W(8), .TILE_H(8), .COORD_W(8), .ADDR_W(12),
        .ROM_LATENCY(2), .KEY_EN(1'b1), .KEY_RGB(24'hFF00FF)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .tile_addr(tile_addr),
        .x_pos(x_pos), .y_pos(y_pos), .flip_x(flip_x), .rom_addr(rom_addr),
        .rom_data(rom_data), .vga_ready(vga_ready), .vga_x(vga_x), .vga_y(vga_y),
        .vga_rgb(vga_rgb), .vga_plot(vga_plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // ROM with 2-cycle latency: data for an address is only valid two edges after it appears.
    logic [7:0]  mem [4096];
    logic [11:0] rom_pipe = '0;
    always @(posedge clk) rom_pipe <= rom_addr;
    assign rom_data = mem[rom_pipe];

    int          cyc = 0;
    int          done_cnt = 0;
    plot_t       got[$];
    int          got_cyc[$];
    logic [11:0] addr_seen[$];
    plot_t       exp_q[$];

    always @(negedge clk) begin
        cyc++;
        if (vga_plot === 1'b1 && vga_ready === 1'b1) begin
            got.push_back({vga_x, vga_y, vga_rgb});
            got_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1 && (addr_seen.size() == 0 || addr_seen[$] != rom_addr))
            addr_seen.push_back(rom_addr);
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) vga_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
    endtask

    task automatic put_key(input logic [11:0] a, input int p);
        int base;
        base = int'(a) + 3 * p;
        mem[base % 4096]       = 8'hFF;
        mem[(base + 1) % 4096] = 8'h00;
        mem[(base + 2) % 4096] = 8'hFF;
    endtask

    // Reference: walk pixels in ROM order, drop key-coloured ones, place on screen.
    task automatic build_exp(input logic [11:0] a, input logic [7:0] x, input logic [7:0] y,
                             input logic f);
        exp_q.delete();
        for (int p = 0; p < 64; p++) begin
            int col;
            int row;
            int base;
            logic [23:0] rgb;
            col  = p % 8;
            row  = p / 8;
            base = int'(a) + 3 * p;
            rgb  = {mem[base % 4096], mem[(base + 1) % 4096], mem[(base + 2) % 4096]};
            if (rgb != 24'hFF00FF)
                exp_q.push_back({8'(int'(x) + (f ? 7 - col : col)), 8'(int'(y) + row), rgb});
        end
    endtask

    task automatic compare_plots(input string tag);
        int n;
        chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_plot%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    endtask

    task automatic clear_obs();
        got.delete();
        got_cyc.delete();
        addr_seen.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [11:0] a, input logic [7:0] x, input logic [7:0] y,
                               input logic f);
        tile_addr = a; x_pos = x; y_pos = y; flip_x = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic run_tile(input string tag, input logic [11:0] a, input logic [7:0] x,
                            input logic [7:0] y, input logic f);
        clear_obs();
        pulse_start(a, x, y, f);
        wait_done(tag);
        build_exp(a, x, y, f);
        compare_plots(tag);
    endtask

    vec_t vecs[3];

    initial begin
        plot_t       hold;
        int          n0;
        int          k;
        logic [11:0] ra;

        vecs[0] = '{12'h000, 8'd10,  8'd20, 1'b0, 64, {8'd10, 8'd20, 24'h000102},
                    {8'd17, 8'd27, 24'hBDBEBF}, 1'b0};
        vecs[1] = '{12'h000, 8'd10,  8'd20, 1'b1, 64, {8'd17, 8'd20, 24'h000102},
                    {8'd10, 8'd27, 24'hBDBEBF}, 1'b0};
        vecs[2] = '{12'hFFE, 8'd250, 8'd0,  1'b0, 64, {8'd250, 8'd0, 24'hFEFF00},
                    {8'd1,  8'd7,  24'hBBBCBD}, 1'b1};

        fill_ramp();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_plot", 64'(vga_plot === 1'b1), 64'd0);
        chk("reset_rom_addr", 64'(rom_addr), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Fixed tiles: plain, flipped, wrapping coordinates and address.
        for (int i = 0; i < 3; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_tile(tag, vecs[i].a, vecs[i].x, vecs[i].y, vecs[i].f);
            chk({tag, "_n"}, 64'(got.size()), 64'(vecs[i].n));
            if (got.size() > 0) begin
                chk({tag, "_first"}, 64'(got[0]), 64'(vecs[i].first));
                chk({tag, "_last"}, 64'(got[$]), 64'(vecs[i].last));
            end
            if (got_cyc.size() > 1)
                chk({tag, "_pixel_gap"}, 64'(got_cyc[1] - got_cyc[0]), 64'd11);
            if (vecs[i].chk_wrap && addr_seen.size() >= 3) begin
                chk({tag, "_addr0"}, 64'(addr_seen[0]), 64'h FFE);
                chk({tag, "_addr1"}, 64'(addr_seen[1]), 64'h FFF);
                chk({tag, "_addr2"}, 64'(addr_seen[2]), 64'h000);
            end
        end

        // Stall pixel 3 for five cycles; bus must hold still and accept exactly once.
        clear_obs();
        pulse_start(12'h000, 8'd10, 8'd20, 1'b0);
        k = 0;
        while (!(got.size() == 3 && vga_plot === 1'b1) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("stall_reached", 64'(got.size() == 3 && vga_plot === 1'b1), 64'd1);
        vga_ready = 1'b0;
        hold = {vga_x, vga_y, vga_rgb};
        chk("stall_pixel3", 64'(hold), 64'({8'd13, 8'd20, 24'h090A0B}));
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall_hold", 64'({vga_plot, vga_x, vga_y, vga_rgb}), 64'({1'b1, hold}));
        end
        vga_ready = 1'b1;
        wait_done("stall");
        build_exp(12'h000, 8'd10, 8'd20, 1'b0);
        compare_plots("stall");

        // Colour key on pixels 5 and 63.
        put_key(12'h000, 5);
        put_key(12'h000, 63);
        run_tile("key", 12'h000, 8'd10, 8'd20, 1'b0);
        chk("key_n", 64'(got.size()), 64'd62);
        k = 0;
        foreach (got[i])
            if (got[i][39:24] == {8'd15, 8'd20} || got[i][39:24] == {8'd17, 8'd27}) k++;
        chk("key_coords_absent", 64'(k), 64'd0);
        fill_ramp();

        // Extra starts while busy, then reset (together with start) part-way through pixel 10.
        clear_obs();
        pulse_start(12'h000, 8'd10, 8'd20, 1'b0);
        k = 0;
        while (got.size() < 5 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        pulse_start(12'h300, 8'd100, 8'd100, 1'b1);
        pulse_start(12'h300, 8'd100, 8'd100, 1'b1);
        k = 0;
        while (got.size() < 10 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        chk("abort_reached10", 64'(got.size()), 64'd10);
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_plot", 64'(vga_plot === 1'b1), 64'd0);
        n0 = got.size();
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_plots", 64'(got.size()), 64'(n0));
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);
        build_exp(12'h000, 8'd10, 8'd20, 1'b0);
        for (int i = 0; i < n0 && i < exp_q.size(); i++)
            chk($sformatf("abort_prefix%0d", i), 64'(got[i]), 64'(exp_q[i]));
        run_tile("after_reset", 12'h000, 8'd10, 8'd20, 1'b0);

        // Random tiles with random ROM contents, key pixels and backpressure.
        rdy_rand = 1'b1;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
            ra = 12'($urandom);
            repeat (int'($urandom_range(0, 4))) put_key(ra, int'($urandom_range(0, 63)));
            run_tile($sformatf("rand%0d", t), ra, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        rdy_rand = 1'b0;
        vga_ready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
